// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz raster timing generator.
// Divides clk down to a pixel-rate tick, runs the horizontal/vertical
// counters and registers the sync, blanking and visible-coordinate decode.
// Optional feature: define VGA_SYNC_FRAME_CNT_EN to build the 8-bit frame
// counter on frame_cnt; otherwise frame_cnt is tied to zero.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       clr,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_on,
  output logic [9:0] Pixel_X,
  output logic [8:0] Pixel_Y,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
  logic             pixel_tick_d, pixel_tick_q;
  logic [9:0]       h_cnt_d, h_cnt_q;
  logic [9:0]       v_cnt_d, v_cnt_q;
  logic             hsync_d, hsync_q;
  logic             vsync_d, vsync_q;
  logic             vga_on_d, vga_on_q;
  logic [9:0]       pixel_x_d, pixel_x_q;
  logic [8:0]       pixel_y_d, pixel_y_q;
  logic             frame_start_d, frame_start_q;
  logic             visible;

  // Clock divider: wrap at CLK_DIV-1 and raise the tick for the next cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    div_cnt_d    = div_cnt_q + DIV_W'(1);
    pixel_tick_d = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d    = '0;
      pixel_tick_d = 1'b1;
    end
  end

  // Raster step: decode the current (h,v) into the outputs, then advance.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    vga_on_d      = vga_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_start_d = 1'b0;
    visible       = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
    if (pixel_tick_q) begin
      vga_on_d      = visible;
      hsync_d       = !((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST));
      vsync_d       = !((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST));
      pixel_x_d     = visible ? h_cnt_q : 10'd0;
      pixel_y_d     = visible ? v_cnt_q[8:0] : 9'd0;
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // State registers; clr clears everything so the raster restarts at (0,0).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_cnt_q     <= '0;
      pixel_tick_q  <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      vga_on_q      <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 9'd0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      div_cnt_q     <= div_cnt_d;
      pixel_tick_q  <= pixel_tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vga_on_q      <= vga_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_d, frame_cnt_q;

  // Frame counter advances together with the frame_start pulse; wraps 255->0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) frame_cnt_q <= 8'd0;
    else      frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

  assign pixel_tick  = pixel_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_on      = vga_on_q;
  assign Pixel_X     = pixel_x_q;
  assign Pixel_Y     = pixel_y_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
// dut_a: default 640x480 raster, CLK_DIV=4 (reset, first frame, line timing).
// dut_b: default raster, CLK_DIV=1 (continuous tick, 800-clk line).
// dut_c: miniature raster (H 8/2/3/2 = 15, V 6/1/2/2 = 11), CLK_DIV=1, so
//        whole frames, 257-frame counter wrap and mid-frame reset fit in a
//        short run. Expected frame_cnt follows VGA_SYNC_FRAME_CNT_EN.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_b, clr_c;

  logic       a_tick, a_hs, a_vs, a_on, a_fs;
  logic [9:0] a_px;
  logic [8:0] a_py;
  logic [7:0] a_fc;
  logic       b_tick, b_hs, b_vs, b_on, b_fs;
  logic [9:0] b_px;
  logic [8:0] b_py;
  logic [7:0] b_fc;
  logic       c_tick, c_hs, c_vs, c_on, c_fs;
  logic [9:0] c_px;
  logic [8:0] c_py;
  logic [7:0] c_fc;

  int n_cmp = 0;
  int n_bad = 0;

  vga_sync_gen #(.CLK_DIV(4)) dut_a (
    .clk(clk), .clr(clr_a), .pixel_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
    .vga_on(a_on), .Pixel_X(a_px), .Pixel_Y(a_py), .frame_start(a_fs),
    .frame_cnt(a_fc)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut_b (
    .clk(clk), .clr(clr_b), .pixel_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
    .vga_on(b_on), .Pixel_X(b_px), .Pixel_Y(b_py), .frame_start(b_fs),
    .frame_cnt(b_fc)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_c (
    .clk(clk), .clr(clr_c), .pixel_tick(c_tick), .hsync(c_hs), .vsync(c_vs),
    .vga_on(c_on), .Pixel_X(c_px), .Pixel_Y(c_py), .frame_start(c_fs),
    .frame_cnt(c_fc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected frame counter value after a given number of frame starts.
  function automatic logic [7:0] fc_exp(input int frames);
`ifdef VGA_SYNC_FRAME_CNT_EN
    return 8'(frames);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check_idle(input string tag, input logic tick, input logic hs,
                            input logic vs, input logic on, input logic [9:0] px,
                            input logic [8:0] py, input logic fs, input logic [7:0] fc);
    check({tag, "_tick"}, tick, 1'b0);
    check({tag, "_hsync"}, hs, 1'b1);
    check({tag, "_vsync"}, vs, 1'b1);
    check({tag, "_vga_on"}, on, 1'b0);
    check({tag, "_px"}, px, 10'd0);
    check({tag, "_py"}, py, 9'd0);
    check({tag, "_fs"}, fs, 1'b0);
    check({tag, "_fc"}, fc, 8'd0);
  endtask

  // Watchdog: the directed sequence needs well under 1 ms of sim time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, fall1, fall2, hs_low, on_cnt, tick_cnt, tick_low, px_err, px_max;
    int vs_low, vs_fall, extra_fs, nfs, fs1_t, fs2_t, py_max;
    logic prev_hs, prev_vs;

    clr_a = 1'b0;
    clr_b = 1'b0;
    clr_c = 1'b0;
    repeat (20) @(negedge clk);
    check_idle("a_rst", a_tick, a_hs, a_vs, a_on, a_px, a_py, a_fs, a_fc);
    check_idle("c_rst", c_tick, c_hs, c_vs, c_on, c_px, c_py, c_fs, c_fc);

    // ---------------- dut_a: CLK_DIV=4 ----------------
    clr_a = 1'b1;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (a_fs) begin k = i; break; end
    end
    check("a_first_fs_latency", k, 5);
    check("a_first_on", a_on, 1'b1);
    check("a_first_px", a_px, 0);
    check("a_first_py", a_py, 0);
    check("a_first_fc", a_fc, fc_exp(1));

    // t=0 is the sample presenting (0,0); step through two lines.
    prev_hs = a_hs; fall1 = -1; fall2 = -1; hs_low = 0; on_cnt = 32'(a_on);
    tick_cnt = 0; px_err = 0; px_max = 0; vs_low = 0; extra_fs = 0;
    for (int t = 1; t < 6000; t++) begin
      @(negedge clk);
      if (prev_hs && !a_hs) begin
        if (fall1 < 0) fall1 = t;
        else if (fall2 < 0) fall2 = t;
      end
      prev_hs = a_hs;
      if (a_fs) extra_fs++;
      if (!a_vs) vs_low++;
      if (t < 3200) begin
        if (!a_hs) hs_low++;
        if (a_on) on_cnt++;
        if (a_px != ((t / 4 < 640) ? 10'(t / 4) : 10'd0)) px_err++;
        if (a_on && int'(a_px) > px_max) px_max = int'(a_px);
      end
      if (t <= 3200 && a_tick) tick_cnt++;
      if (t == 3200) begin
        check("a_line1_px", a_px, 0);
        check("a_line1_py", a_py, 1);
      end
    end
    check("a_hsync_first_fall", fall1, 2624);
    check("a_hsync_fall_period", fall2 - fall1, 3200);
    check("a_hsync_low_width", hs_low, 384);
    check("a_vga_on_per_line", on_cnt, 2560);
    check("a_px_sequence_errors", px_err, 0);
    check("a_px_max", px_max, 639);
    check("a_ticks_per_line", tick_cnt, 800);
    check("a_vsync_low_in_lines_0_1", vs_low, 0);
    check("a_extra_frame_start", extra_fs, 0);

    // ---------------- dut_b: CLK_DIV=1 ----------------
    check("b_tick_in_reset", b_tick, 1'b0);
    clr_b = 1'b1;
    prev_hs = 1'b1; fall1 = -1; fall2 = -1; tick_low = 0; px_err = 0; k = 0;
    for (int t = 1; t <= 1500; t++) begin
      @(negedge clk);
      if (!b_tick) tick_low++;
      if (b_fs && k == 0) k = t;
      if (prev_hs && !b_hs) begin
        if (fall1 < 0) fall1 = t;
        else if (fall2 < 0) fall2 = t;
      end
      prev_hs = b_hs;
      if (t >= 2 && t <= 801) begin
        if (b_px != ((t - 2 < 640) ? 10'(t - 2) : 10'd0)) px_err++;
      end
    end
    check("b_first_fs_latency", k, 2);
    check("b_tick_low_after_first_cycle", tick_low, 0);
    check("b_hsync_first_fall", fall1, 658);
    check("b_line_period", fall2 - fall1, 800);
    check("b_px_every_clk_errors", px_err, 0);

    // ---------------- dut_c: miniature raster ----------------
    clr_c = 1'b1;
    nfs = 0; fs1_t = -1; fs2_t = -1; prev_vs = 1'b1; vs_fall = -1;
    vs_low = 0; on_cnt = 0; hs_low = 0; py_max = 0; px_max = 0;
    for (int t = 1; t <= 2 + 165 * 256 + 10; t++) begin
      @(negedge clk);
      if (c_fs) begin
        nfs++;
        if (nfs == 1) fs1_t = t;
        if (nfs == 2) fs2_t = t;
        if (nfs == 1)   check("c_fc_frame1", c_fc, fc_exp(1));
        if (nfs == 255) check("c_fc_frame255", c_fc, fc_exp(255));
        if (nfs == 256) check("c_fc_frame256", c_fc, fc_exp(256));
        if (nfs == 257) check("c_fc_frame257", c_fc, fc_exp(257));
      end
      if (nfs == 1) begin
        if (prev_vs && !c_vs) vs_fall = t - fs1_t;
        if (!c_vs) vs_low++;
        if (!c_hs) hs_low++;
        if (c_on) on_cnt++;
        if (int'(c_py) > py_max) py_max = int'(c_py);
        if (int'(c_px) > px_max) px_max = int'(c_px);
      end
      prev_vs = c_vs;
      if (nfs == 257) break;
    end
    check("c_first_fs_latency", fs1_t, 2);
    check("c_frame_period", fs2_t - fs1_t, 165);
    check("c_frames_seen", nfs, 257);
    check("c_vsync_fall_offset", vs_fall, 105);
    check("c_vsync_low_width", vs_low, 30);
    check("c_hsync_low_per_frame", hs_low, 33);
    check("c_vga_on_per_frame", on_cnt, 48);
    check("c_py_max", py_max, 5);
    check("c_px_max", px_max, 7);

    // Mid-frame reset while presenting visible pixel (5,4).
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (c_on && c_px == 10'd5 && c_py == 9'd4) begin k = i; break; end
    end
    check("c_reached_5_4", k, 65);
    clr_c = 1'b0;
    #1;
    check_idle("c_mid_rst", c_tick, c_hs, c_vs, c_on, c_px, c_py, c_fs, c_fc);
    repeat (3) @(negedge clk);
    check("c_mid_rst_held_px", c_px, 0);
    clr_c = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (c_fs) begin k = i; break; end
    end
    check("c_restart_fs_latency", k, 2);
    check("c_restart_on", c_on, 1'b1);
    check("c_restart_px", c_px, 0);
    check("c_restart_py", c_py, 0);
    check("c_restart_fc", c_fc, fc_exp(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. It sits directly upstream of the tic-tac-toe pixel logic and supplies that logic's `vga_on`, `Pixel_X` and `Pixel_Y` inputs. It also drives the monitor's `hsync` and `vsync` pins. The block divides the system clock down to a pixel-rate enable, runs the horizontal and vertical counters, and decodes sync, blanking and visible-area coordinates for 640x480@60 Hz.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; legal range 1..16. The default gives a 25 MHz pixel rate from a 100 MHz `clk`.
- `H_VISIBLE`, `H_FP`, `H_SYNC`, `H_BP`: 640, 16, 96, 48. Horizontal visible, front-porch, sync and back-porch widths, in pixels.
- `V_VISIBLE`, `V_FP`, `V_SYNC`, `V_BP`: 480, 10, 2, 33. Vertical visible, front-porch, sync and back-porch heights, in lines.
- `clk`, in, 1: system clock. This is the only clock.
- `clr`, in, 1: reset, asynchronous, active-low.
- `pixel_tick`, out, 1: one-`clk` pulse, once every `CLK_DIV` cycles. All other outputs change only in the cycle after a `pixel_tick`.
- `hsync`, out, 1: horizontal sync, active-low.
- `vsync`, out, 1: vertical sync, active-low.
- `vga_on`, out, 1: high while the presented pixel is inside the visible area.
- `Pixel_X`, out, 10: visible column, 0..639. Forced to 0 when `vga_on`=0.
- `Pixel_Y`, out, 9: visible row, 0..479. Forced to 0 when `vga_on`=0.
- `frame_start`, out, 1: one-`clk` pulse in the same cycle the outputs first present pixel (0,0).
- `frame_cnt`, out, 8: frame counter. Only active with the macro in the Configuration section compiled in.

## Operation
- **Divider:** `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `pixel_tick` is registered and asserts in the cycle after `div_cnt`=`CLK_DIV`-1. With `CLK_DIV`=1, `pixel_tick` is high every cycle after the first post-reset cycle.
- **Counters:** `h_cnt` and `v_cnt` are each 10 bits.
  - H_TOTAL = 800 and V_TOTAL = 525 (sums of the parameters).
  - On each tick, `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments.
  - `v_cnt` wraps to 0 at V_TOTAL-1, only when `h_cnt` also wraps.
- **Decode:** registered, using the counter values before they advance on the same tick.
  - `vga_on` = (`h_cnt` < H_VISIBLE) && (`v_cnt` < V_VISIBLE).
  - `hsync` = 0 for `h_cnt` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. 656..751.
  - `vsync` = 0 for `v_cnt` in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. 490..491.
  - `Pixel_X`/`Pixel_Y` = `h_cnt`/`v_cnt[8:0]` when visible, otherwise 0.
  - `frame_start` = 1 when `h_cnt`=0 && `v_cnt`=0. Outside that tick's output-update cycle it is 0.
- **Counter widths:** counters never exceed TOTAL-1. There is no saturation; wrap is the only boundary behaviour.
- **Reset** (asynchronous assert, any time including mid-line):
  - `div_cnt`, `h_cnt` and `v_cnt` go to 0.
  - `pixel_tick`=0, `hsync`=1, `vsync`=1, `vga_on`=0, `Pixel_X`=0, `Pixel_Y`=0, `frame_start`=0, `frame_cnt`=0.
  - Release restarts the raster from pixel (0,0). There is no partial-frame carry-over.
- There is no state machine beyond the counters. Visible, front-porch, sync and back-porch regions are purely decoded from the counts.

## Timing
- **Output latency:** 1 `clk` from the tick sampling (h,v) to the outputs presenting (h,v).
- **First frame after reset release:** the first tick occurs `CLK_DIV` cycles after release. The outputs present (0,0) with `frame_start`=1 and `vga_on`=1 in the following cycle.
- **Hold between ticks:** outputs hold for `CLK_DIV` cycles between updates. The downstream pixel logic samples combinationally and needs no handshake.
- **Periods:**
  - Line period = 800 ticks = 800·`CLK_DIV` clk.
  - Frame period = 420000 ticks.
  - hsync low width = 96 ticks.
  - vsync low width = 2 lines = 1600 ticks.
- **vsync edges:** transitions coincide with the output update for `h_cnt`=0 of lines 490 and 492.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined: `frame_cnt` increments by 1 in the cycle `frame_start` is high.
  - Wraps 255→0.
  - Reset value is 0.
  - The count of the first frame after reset is 1.
  - Used for cursor blink and win-flash timing.
- `VGA_SYNC_FRAME_CNT_EN` undefined: `frame_cnt` is tied to 8'd0 and no counter is synthesised. The port list is identical either way.

## Test plan
- **Reset:** hold `clr`=0, toggle `clk` for 20 cycles. Required: `hsync`=1, `vsync`=1, `vga_on`=0, `Pixel_X`=0, `Pixel_Y`=0, `frame_start`=0, `frame_cnt`=0. Release `clr`; the first `frame_start` appears exactly 5 clk later with `CLK_DIV`=4.
- **Line timing, `CLK_DIV`=4:**
  - Consecutive `hsync` falling edges are 3200 clk apart.
  - `hsync` low is 384 clk.
  - `vga_on` high is 2560 clk per visible line.
  - `Pixel_X` steps 0..639 with no gaps.
- **Frame timing:**
  - `vsync` low is 3200·2 clk.
  - `frame_start` pulses are 1680000 clk apart.
  - `vga_on` is high for exactly 307200 ticks per frame.
  - `Pixel_Y` ends at 479.
- **Mid-frame reset:** run to `v_cnt`=300, `h_cnt`=400, then pulse `clr` low for 3 clk. Outputs go to reset values immediately, asynchronously. After release the next presented pixel is (0,0) with `frame_start`=1.
- **Frame counter:** with `VGA_SYNC_FRAME_CNT_EN` defined, run 257 frames. `frame_cnt` reads 255 after frame 255, 0 after frame 256, and 1 after frame 257. With the macro undefined, it stays 0 throughout.
- **`CLK_DIV`=1:** `pixel_tick` is constantly high after the first post-reset cycle, the line period is 800 clk, and `Pixel_X` increments every clk.
